sdram_read_fetcher: RTL and testbench

//  Read sequencer between the SDRAM controller's single-word read port and a pixel/data consumer.
//  - Takes a start pulse, a base address and a word count.
//  - Issues one read_command per word to sdram_controller_test and captures odata on read_finished.
//  - Buffers the words in a FIFO and presents them on a ready/valid stream (VGA line fetch, hex debug).

---
 rtl/sdram_fetch_pkg.sv | 17 +
 rtl/sdram_fetch_fifo.sv | 70 +++++++
 rtl/sdram_read_fetcher.sv | 135 +++++++++++++
 tb/tb_sdram_read_fetcher.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_fetch_pkg.sv
// Shared types and default sizes for the SDRAM read fetcher.
package sdram_fetch_pkg;

  localparam int ADDR_W_DEF     = 25;
  localparam int DATA_W_DEF     = 16;
  localparam int CNT_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int TIMEOUT_DEF    = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/sdram_fetch_fifo.sv
// Synchronous FIFO with a registered head word; rd_valid/rd_data are flops,
// so there is no combinational path from wr_data to rd_data.
module sdram_fetch_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]    count_reg, count_next;
  logic [DATA_W-1:0] head_reg, head_next;
  logic              valid_reg;
  logic              push, pop;
  logic [PTR_W:0]    push_w, pop_w;

  assign pop    = rd_ready && valid_reg;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push   = wr_en && ((count_reg != (PTR_W+1)'(DEPTH)) || pop);
  assign push_w = (PTR_W+1)'(push);
  assign pop_w  = (PTR_W+1)'(pop);

  always_comb begin
    count_next  = count_reg + push_w - pop_w;
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    head_next   = head_reg;
    if (count_next != '0) begin
      // Storage drains to nothing this cycle: the incoming word becomes the head.
      if ((count_reg - pop_w) == '0)
        head_next = wr_data;
      else
        head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      valid_reg  <= (count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data  = head_reg;
  assign rd_valid = valid_reg;
  assign count    = count_reg;

endmodule

// File: rtl/sdram_read_fetcher.sv
// Sequences single-word SDRAM reads into a ready/valid stream.
// Optional per-read watchdog enabled by defining SDRAM_FETCH_TIMEOUT_EN.
module sdram_read_fetcher
  import sdram_fetch_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              MAX10_CLK1_50,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              read_command,
  output logic [ADDR_W-1:0] address,
  input  logic              read_finished,
  input  logic [DATA_W-1:0] odata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_free;
  logic              push;
  logic              accept;
  logic              timeout_hit;

  assign accept    = (state_reg == IDLE) && start;
  assign push      = (state_reg == WAIT) && read_finished;
  // Only ISSUE consults this, when no read is outstanding, so a push always has room.
  assign fifo_free = (fifo_count != FCNT_W'(FIFO_DEPTH));

`ifdef SDRAM_FETCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  logic [TMR_W-1:0] timer_reg;
  logic             error_reg;

  assign timeout_hit = (state_reg == WAIT) && !read_finished &&
                       (timer_reg == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      timer_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      if ((state_reg != WAIT) || push)
        timer_reg <= '0;
      else
        timer_reg <= timer_reg + TMR_W'(1);
      if (accept)
        error_reg <= 1'b0;
      else if (timeout_hit)
        error_reg <= 1'b1;
    end
  end

  assign error = error_reg;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
    if (!Reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (start) state_next = (word_count == '0) ? DONE : ISSUE;
      ISSUE: if (fifo_free) state_next = WAIT;
      WAIT: begin
        if (push)
          state_next = (remaining_reg == CNT_W'(1)) ? DONE : ISSUE;
        else if (timeout_hit)
          state_next = DONE;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request is a pure state decode: WAIT always passes through ISSUE (or DONE),
  // which guarantees a low cycle between consecutive reads.
  always_comb begin
    busy         = (state_reg != IDLE) || start;
    done         = (state_reg == DONE);
    read_command = (state_reg == WAIT);
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
    end else if (accept) begin
      addr_reg      <= base_addr;
      remaining_reg <= word_count;
    end else if (push) begin
      addr_reg      <= addr_reg + ADDR_W'(1);
      remaining_reg <= remaining_reg - CNT_W'(1);
    end
  end

  assign address = addr_reg;

  sdram_fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (MAX10_CLK1_50),
    .rst_n    (Reset_n),
    .wr_en    (push),
    .wr_data  (odata),
    .rd_ready (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_sdram_read_fetcher.sv
// Directed bench for sdram_read_fetcher with a 3-cycle controller model
// that answers each read with address[15:0] ^ 16'hA5A5.
module tb_sdram_read_fetcher;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy, done, error, read_command;
  logic [ADDR_W-1:0] address;
  logic              read_finished = 1'b0;
  logic [DATA_W-1:0] odata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;

  always #5 clk = ~clk;

  sdram_read_fetcher #(.TIMEOUT(16)) dut (
    .MAX10_CLK1_50 (clk),
    .Reset_n       (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .read_command  (read_command),
    .address       (address),
    .read_finished (read_finished),
    .odata         (odata),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Controller model: logs each new request, answers after 3 cycles of read_command.
  logic [ADDR_W-1:0] issued_q[$];
  int                lat = 0;
  int                rc_rises = 0;
  logic              prev_rc = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  bit                ctrl_en = 1'b1;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      read_finished = 1'b0;
      lat = 0;
      prev_rc = 1'b0;
    end else begin
      if (read_command && !prev_rc) begin
        issued_q.push_back(address);
        rc_rises++;
      end
      if (read_command && prev_rc) check_eq("addr_stable", 32'(address), 32'(prev_addr));
      prev_rc   = read_command;
      prev_addr = address;
      if (read_finished) begin
        read_finished = 1'b0;
        lat = 0;
        check_eq("rc_gap", 32'(read_command), 32'd0);
      end else if (read_command && ctrl_en) begin
        lat++;
        if (lat == 3) begin
          read_finished = 1'b1;
          odata = address[15:0] ^ 16'hA5A5;
        end
      end else begin
        lat = 0;
      end
    end
  end

  int done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
    @(negedge clk);
    base_addr  = a;
    word_count = n;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done_cnt(input string tag, input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic pop_expect(input string tag, input logic [DATA_W-1:0] exp);
    int c = 0;
    while (!out_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, 32'({out_valid, out_data}), 32'({1'b1, exp}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, 32'({busy, done, error, read_command, out_valid}), 32'd0);
    check_eq({tag, "_addr"}, 32'(address), 32'd0);
    check_eq({tag, "_data"}, 32'(out_data), 32'd0);
  endtask

  initial begin
    int c;
    int r0;

    #2 rst_n = 1'b0;
    tick(3);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // 1: four words from 0x100
    issued_q.delete();
    do_start(25'h100, 16'd4);
    #1 check_eq("t1_issue_state", 32'({busy, read_command}), 32'b10);
    @(negedge clk);
    check_eq("t1_first_req", 32'({read_command, address}), 32'({1'b1, 25'h100}));
    wait_done_cnt("t1_done", 1, 100);
    check_eq("t1_nreads", 32'(issued_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t1_addr%0d", i), 32'(issued_q[i]), 32'h100 + 32'(i));
    pop_expect("t1_w0", 16'hA4A5);
    pop_expect("t1_w1", 16'hA4A4);
    pop_expect("t1_w2", 16'hA4A7);
    pop_expect("t1_w3", 16'hA4A6);
    check_eq("t1_drained", 32'({out_valid, busy}), 32'd0);

    // 2: 40 words with consumer stalled -> FIFO limits reads to 16
    issued_q.delete();
    do_start(25'h2000, 16'd40);
    tick(150);
    check_eq("t2_reads_stalled", 32'(issued_q.size()), 32'd16);
    check_eq("t2_stall_state", 32'({busy, read_command, out_valid}), 32'b101);
    for (int i = 0; i < 40; i++)
      pop_expect($sformatf("t2_w%0d", i), 16'(32'h2000 + 32'(i)) ^ 16'hA5A5);
    check_eq("t2_nreads", 32'(issued_q.size()), 32'd40);
    wait_done_cnt("t2_done", 2, 100);
    tick(2);
    check_eq("t2_idle", 32'({busy, out_valid}), 32'd0);

    // 3: address wrap
    issued_q.delete();
    do_start(25'h1FFFFFE, 16'd3);
    wait_done_cnt("t3_done", 3, 100);
    check_eq("t3_a0", 32'(issued_q[0]), 32'h1FFFFFE);
    check_eq("t3_a1", 32'(issued_q[1]), 32'h1FFFFFF);
    check_eq("t3_a2", 32'(issued_q[2]), 32'h0000000);
    pop_expect("t3_w0", 16'h5A5B);
    pop_expect("t3_w1", 16'h5A5A);
    pop_expect("t3_w2", 16'hA5A5);

    // 4: zero-length transfer
    r0 = rc_rises;
    @(negedge clk);
    word_count = '0;
    start = 1'b1;
    #1 check_eq("t4_cycle1", 32'({busy, done}), 32'b10);
    @(negedge clk);
    start = 1'b0;
    #1 check_eq("t4_cycle2", 32'({busy, done}), 32'b11);
    @(negedge clk);
    #1 check_eq("t4_cycle3", 32'({busy, done}), 32'b00);
    tick(3);
    check_eq("t4_no_reads", 32'(rc_rises), 32'(r0));
    check_eq("t4_done_cnt", 32'(done_cnt), 32'd4);

    // 5: reset during WAIT of word 2, then a normal transfer
    issued_q.delete();
    do_start(25'h300, 16'd8);
    c = 0;
    while (!(read_command && address == 25'h301) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check_eq("t5_reach_word2", 32'({read_command, address}), 32'({1'b1, 25'h301}));
    rst_n = 1'b0;
    #1 check_reset_outputs("t5_reset");
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    issued_q.delete();
    do_start(25'h400, 16'd2);
    wait_done_cnt("t5_done", 5, 100);
    pop_expect("t5_w0", 16'hA1A5);
    pop_expect("t5_w1", 16'hA1A4);
    check_eq("t5_drained", 32'(out_valid), 32'd0);

`ifdef SDRAM_FETCH_TIMEOUT_EN
    // 6: controller never answers -> timeout after 16 WAIT cycles
    ctrl_en = 1'b0;
    do_start(25'h500, 16'd3);
    c = 0;
    while (!read_command && c < 50) begin
      @(negedge clk);
      c++;
    end
    c = 0;
    while (read_command && c < 100) begin
      c++;
      @(negedge clk);
    end
    check_eq("t6_wait_len", 32'(c), 32'd16);
    check_eq("t6_err_done", 32'({error, done}), 32'b11);
    ctrl_en = 1'b1;
    do_start(25'h600, 16'd1);
    #1 check_eq("t6_err_clear", 32'(error), 32'd0);
    wait_done_cnt("t6_done", 7, 100);
    pop_expect("t6_w0", 16'hA3A5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
